// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard byte constants, host command FSM states and parity helper.
package ps2_pkg;

    localparam logic [7:0] PS2_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RESEND   = 8'hFE;
    localparam logic [7:0] PS2_SET_LED  = 8'hED;
    localparam logic [7:0] PS2_SET_RATE = 8'hF3;
    localparam logic [7:0] PS2_RESET    = 8'hFF;
    localparam logic [7:0] PS2_BAT_OK   = 8'hAA;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StTxBits,
        StWaitResp,
        StDone,
        StFail
    } ps2_state_e;

    // Odd parity bit for a PS/2 frame: set when the byte holds an even number of ones.
    function automatic logic odd_parity(input logic [7:0] value);
        return ~^value;
    endfunction

endpackage

// File: rtl/ps2_tx_shifter.sv
// Bit-level host-to-device frame shifter: start bit on load, then 8 data bits, parity,
// stop release and line-ACK sampling, each advanced by one PS/2 clock falling edge.
module ps2_tx_shifter
    import ps2_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       clear,
    input  logic [7:0] tx_byte,
    input  logic       fall_edge,
    input  logic       data_sync,
    output logic       data_oe,
    output logic       done,
    output logic       nack
);

    logic       active_q, active_d;
    logic [3:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_q, parity_d;
    logic       data_oe_q, data_oe_d;

    // Edge 11 is the line-ACK sample; the device holds data low to acknowledge.
    always_comb begin
        done = active_q & fall_edge & (bit_idx_q == 4'd10);
        nack = done & data_sync;
    end

    // Next-state: clear aborts, load drives the start bit, each edge drives the next bit.
    always_comb begin
        active_d  = active_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        data_oe_d = data_oe_q;
        if (clear) begin
            active_d  = 1'b0;
            data_oe_d = 1'b0;
        end else if (load) begin
            active_d  = 1'b1;
            bit_idx_d = 4'd0;
            shift_d   = tx_byte;
            parity_d  = odd_parity(tx_byte);
            data_oe_d = 1'b1;
        end else if (active_q && fall_edge) begin
            bit_idx_d = bit_idx_q + 4'd1;
            if (bit_idx_q < 4'd8) begin
                // Open drain: pull low for a 0 bit, LSB first.
                data_oe_d = ~shift_q[0];
                shift_d   = {1'b0, shift_q[7:1]};
            end else if (bit_idx_q == 4'd8) begin
                data_oe_d = ~parity_q;
            end else if (bit_idx_q == 4'd9) begin
                data_oe_d = 1'b0;
            end else begin
                active_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        end
    end

    // Shifter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= 1'b0;
            bit_idx_q <= 4'd0;
            shift_q   <= 8'd0;
            parity_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            active_q  <= active_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            data_oe_q <= data_oe_d;
        end
    end

    assign data_oe = data_oe_q;

endmodule

// File: rtl/ps2_host_cmd_ctrl.sv
// PS/2 host command sequencer: inhibit, request-to-send, frame transmit, FA/FE response
// handling with resends, per-phase timeouts and a single done/error result per command.
module ps2_host_cmd_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned INHIBIT_US = 100,
    parameter int unsigned TIMEOUT_MS = 20,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_has_arg,
    input  logic [7:0] cmd_arg,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       ps2_clk_async,
    input  logic       ps2_data_async,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       rx_owned,
    output logic       done,
    output logic       error
);

    localparam int unsigned INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int unsigned TO_CYC      = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int unsigned CNT_MAX     = (TO_CYC > INHIBIT_CYC) ? TO_CYC : INHIBIT_CYC;
    localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);
    localparam int unsigned RETRY_W     = $clog2(MAX_RETRY + 2);

    localparam logic [CNT_W-1:0]   INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0]   TO_LAST      = CNT_W'(TO_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

    ps2_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic [7:0]         arg_q, arg_d;
    logic               arg_pend_q, arg_pend_d;

    logic clk_s1, clk_s2, clk_s3;
    logic data_s1, data_s2;
    logic fall_edge, tx_fall;
    logic tx_load, tx_abort, tx_done, tx_nack;

    logic cmd_ready_q, cmd_ready_d;
    logic busy_q, busy_d;
    logic clk_oe_q, clk_oe_d;
    logic rx_owned_q, rx_owned_d;
    logic done_q, done_d;
    logic error_q, error_d;

    // Two-flop synchronizers plus one history flop on the clock line for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk_async;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= ps2_data_async;
            data_s2 <= data_s1;
        end
    end

    assign fall_edge = clk_s3 & ~clk_s2;
    // Edges seen while inhibiting (our own pull-down) or in RTS are not device clocks.
    assign tx_fall   = fall_edge & (state_q == StTxBits);

    ps2_tx_shifter u_tx_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tx_load),
        .clear     (tx_abort),
        .tx_byte   (tx_byte_q),
        .fall_edge (tx_fall),
        .data_sync (data_s2),
        .data_oe   (ps2_data_oe),
        .done      (tx_done),
        .nack      (tx_nack)
    );

    // Next-state: command latch, inhibit timing, response decode, retries and timeouts.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        retry_d    = retry_q;
        tx_byte_d  = tx_byte_q;
        arg_d      = arg_q;
        arg_pend_d = arg_pend_q;
        tx_load    = 1'b0;
        tx_abort   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    tx_byte_d  = cmd_byte;
                    arg_d      = cmd_arg;
                    arg_pend_d = cmd_has_arg;
                    retry_d    = '0;
                    cnt_d      = '0;
                    state_d    = StInhibit;
                end
            end
            StInhibit: begin
                if (cnt_q == INHIBIT_LAST) begin
                    cnt_d   = '0;
                    tx_load = 1'b1;
                    state_d = StRts;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRts: begin
                cnt_d   = '0;
                state_d = StTxBits;
            end
            StTxBits: begin
                // A device edge outranks a timeout landing in the same cycle.
                if (tx_done) begin
                    cnt_d   = '0;
                    state_d = tx_nack ? StFail : StWaitResp;
                end else if (tx_fall) begin
                    cnt_d = '0;
                end else if (cnt_q == TO_LAST) begin
                    tx_abort = 1'b1;
                    state_d  = StFail;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitResp: begin
                if (rx_valid && (rx_byte == PS2_ACK)) begin
                    if (arg_pend_q) begin
                        tx_byte_d  = arg_q;
                        arg_pend_d = 1'b0;
                        retry_d    = '0;
                        cnt_d      = '0;
                        state_d    = StInhibit;
                    end else begin
                        state_d = StDone;
                    end
                end else if (rx_valid && (rx_byte == PS2_RESEND)) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        cnt_d   = '0;
                        state_d = StInhibit;
                    end else begin
                        state_d = StFail;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d = StFail;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone, StFail: state_d = StIdle;
            default:        state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        cmd_ready_d = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
        clk_oe_d    = (state_d == StInhibit);
        rx_owned_d  = (state_d == StWaitResp);
        done_d      = (state_d == StDone) || (state_d == StFail);
        error_d     = (state_d == StFail);
    end

    // FSM, counters, latched command and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            retry_q     <= '0;
            tx_byte_q   <= 8'd0;
            arg_q       <= 8'd0;
            arg_pend_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            clk_oe_q    <= 1'b0;
            rx_owned_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            tx_byte_q   <= tx_byte_d;
            arg_q       <= arg_d;
            arg_pend_q  <= arg_pend_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            clk_oe_q    <= clk_oe_d;
            rx_owned_q  <= rx_owned_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign ps2_clk_oe = clk_oe_q;
    assign rx_owned   = rx_owned_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
